// File: rtl/ram_wb_arbiter.sv
// Purpose: two-master Wishbone B3 arbiter (round-robin, whole-cycle grants) in front of one RAM slave port.
// Latency: grant one clock after cyc rises from IDLE; request mux and ack/err/rty/dat response paths are combinational.
// Backpressure: a waiting master holds cyc/stb with no ack until granted; optional stall watchdog via RAM_WB_ARB_WATCHDOG_EN.
module ram_wb_arbiter #(
    parameter int dw          = 32,
    parameter int aw          = 32,
    parameter int WDOG_CYCLES = 256
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,

    input  logic [aw-1:0] m0_adr_i,
    input  logic [dw-1:0] m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [2:0]    m0_cti_i,
    input  logic [1:0]    m0_bte_i,
    input  logic          m0_we_i,
    input  logic          m0_stb_i,
    input  logic          m0_cyc_i,
    output logic [dw-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic          m0_rty_o,

    input  logic [aw-1:0] m1_adr_i,
    input  logic [dw-1:0] m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [2:0]    m1_cti_i,
    input  logic [1:0]    m1_bte_i,
    input  logic          m1_we_i,
    input  logic          m1_stb_i,
    input  logic          m1_cyc_i,
    output logic [dw-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          m1_rty_o,

    output logic [aw-1:0] s_adr_o,
    output logic [dw-1:0] s_dat_o,
    output logic [3:0]    s_sel_o,
    output logic [2:0]    s_cti_o,
    output logic [1:0]    s_bte_o,
    output logic          s_we_o,
    output logic          s_stb_o,
    output logic          s_cyc_o,
    input  logic [dw-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    input  logic          s_rty_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT0  = 2'd1;
    localparam logic [1:0] ST_GNT1  = 2'd2;
`ifdef RAM_WB_ARB_WATCHDOG_EN
    localparam logic [1:0] ST_ABORT = 2'd3;
`endif

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [1:0] idle_pick;
    logic       last;        // 0: m0 granted most recently, 1: m1
    logic       gnt0;
    logic       gnt1;
    logic       wdog_hit;

    assign gnt0 = (state == ST_GNT0);
    assign gnt1 = (state == ST_GNT1);

    // Tie goes to the master that was not served last.
    always_comb begin
        idle_pick = ST_IDLE;
        if (m0_cyc_i && m1_cyc_i)
            idle_pick = last ? ST_GNT0 : ST_GNT1;
        else if (m0_cyc_i)
            idle_pick = ST_GNT0;
        else if (m1_cyc_i)
            idle_pick = ST_GNT1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = idle_pick;
            ST_GNT0: begin
                if (!m0_cyc_i)
                    state_nxt = m1_cyc_i ? ST_GNT1 : ST_IDLE;
`ifdef RAM_WB_ARB_WATCHDOG_EN
                if (wdog_hit)
                    state_nxt = ST_ABORT;
`endif
            end
            ST_GNT1: begin
                if (!m1_cyc_i)
                    state_nxt = m0_cyc_i ? ST_GNT0 : ST_IDLE;
`ifdef RAM_WB_ARB_WATCHDOG_EN
                if (wdog_hit)
                    state_nxt = ST_ABORT;
`endif
            end
            default: begin
`ifdef RAM_WB_ARB_WATCHDOG_EN
                // The aborted master is the one in `last`; wait for it to let go.
                if (!(last ? m1_cyc_i : m0_cyc_i))
                    state_nxt = idle_pick;
`else
                state_nxt = ST_IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt == ST_GNT0 && state != ST_GNT0)
                last <= 1'b0;
            else if (state_nxt == ST_GNT1 && state != ST_GNT1)
                last <= 1'b1;
        end
    end

`ifdef RAM_WB_ARB_WATCHDOG_EN
    localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES);

    logic [15:0] wdog_cnt;

    assign wdog_hit = (gnt0 || gnt1) && (wdog_cnt == WDOG_LIMIT);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)
            wdog_cnt <= 16'd0;
        else if (state_nxt != state || s_ack_i || s_err_i)
            wdog_cnt <= 16'd0;
        else if ((gnt0 || gnt1) && s_stb_o)
            wdog_cnt <= wdog_cnt + 16'd1;
    end
`else
    // Without the watchdog a stalled cycle keeps its grant; the limit can never trip.
    assign wdog_hit = (WDOG_CYCLES < 0);
`endif

    // Idle and abort present m0's address/data with the strobes held low.
    always_comb begin
        s_adr_o = gnt1 ? m1_adr_i : m0_adr_i;
        s_dat_o = gnt1 ? m1_dat_i : m0_dat_i;
        s_sel_o = gnt1 ? m1_sel_i : m0_sel_i;
        s_cti_o = gnt1 ? m1_cti_i : m0_cti_i;
        s_bte_o = gnt1 ? m1_bte_i : m0_bte_i;
        s_cyc_o = ((gnt0 && m0_cyc_i) || (gnt1 && m1_cyc_i)) && !wdog_hit;
        s_stb_o = ((gnt0 && m0_stb_i) || (gnt1 && m1_stb_i)) && !wdog_hit;
        s_we_o  = ((gnt0 && m0_we_i)  || (gnt1 && m1_we_i))  && !wdog_hit;
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign m0_ack_o = gnt0 && s_ack_i && !wdog_hit;
    assign m0_rty_o = gnt0 && s_rty_i && !wdog_hit;
    assign m0_err_o = gnt0 && (s_err_i || wdog_hit);
    assign m1_ack_o = gnt1 && s_ack_i && !wdog_hit;
    assign m1_rty_o = gnt1 && s_rty_i && !wdog_hit;
    assign m1_err_o = gnt1 && (s_err_i || wdog_hit);

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// Directed bench for ram_wb_arbiter with a combinational-ack RAM model (errors at >= 0x00020000).
// Build with RAM_WB_ARB_WATCHDOG_EN to exercise the watchdog abort path (WDOG_CYCLES = 4).
module tb_ram_wb_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i = 1'b0;

    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic [2:0]  m0_cti_i, m1_cti_i;
    logic [1:0]  m0_bte_i, m1_bte_i;
    logic        m0_we_i, m0_stb_i, m0_cyc_i, m1_we_i, m1_stb_i, m1_cyc_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;

    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic [2:0]  s_cti_o;
    logic [1:0]  s_bte_o;
    logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i, s_err_i, s_rty_i;

    logic        stall = 1'b0;
    logic [31:0] wmem [0:255];
    int          npass = 0;
    int          ntotal = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    ram_wb_arbiter #(.dw(32), .aw(32), .WDOG_CYCLES(4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_cti_i(m0_cti_i),
        .m0_bte_i(m0_bte_i), .m0_we_i(m0_we_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_cti_i(m1_cti_i),
        .m1_bte_i(m1_bte_i), .m1_we_i(m1_we_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
        .s_bte_o(s_bte_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
    );

    // RAM model: read data is a fixed pattern of the word index; writes land in wmem.
    always_comb begin
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        if (s_cyc_o && s_stb_o) begin
            if (s_adr_o >= 32'h0002_0000)
                s_err_i = 1'b1;
            else if (!stall)
                s_ack_i = 1'b1;
        end
    end
    assign s_rty_i = 1'b0;
    assign s_dat_i = 32'hA500_0000 | {24'h0, s_adr_o[9:2]};

    always @(posedge wb_clk_i)
        if (s_ack_i && s_we_o && s_sel_o == 4'hF)
            wmem[s_adr_o[9:2]] <= s_dat_o;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic m0_req(input logic [31:0] a, input logic [31:0] d, input logic we,
                          input logic [2:0] cti, input logic [1:0] bte);
        m0_adr_i = a; m0_dat_i = d; m0_we_i = we; m0_cti_i = cti; m0_bte_i = bte;
        m0_sel_i = 4'hF; m0_stb_i = 1'b1; m0_cyc_i = 1'b1;
    endtask

    task automatic m1_req(input logic [31:0] a, input logic [31:0] d, input logic we,
                          input logic [2:0] cti, input logic [1:0] bte);
        m1_adr_i = a; m1_dat_i = d; m1_we_i = we; m1_cti_i = cti; m1_bte_i = bte;
        m1_sel_i = 4'hF; m1_stb_i = 1'b1; m1_cyc_i = 1'b1;
    endtask

    task automatic m0_idle();
        m0_stb_i = 1'b0; m0_cyc_i = 1'b0; m0_we_i = 1'b0;
    endtask

    task automatic m1_idle();
        m1_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_we_i = 1'b0;
    endtask

    task automatic do_reset();
        wb_rst_n_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge wb_clk_i);
        ntotal++;
        if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000)
            $display("FAIL reset_slave_idle: got %b expected 000", {s_cyc_o, s_stb_o, s_we_o});
        else npass++;
        ntotal++;
        if ({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o} !== 6'b0)
            $display("FAIL reset_resp_idle: got %b expected 000000",
                     {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o});
        else npass++;
        tick();
        m0_req(32'h0, 32'h0, 1'b0, 3'b010, 2'b00);
        tick();
        @(negedge wb_clk_i);
        ntotal++;
        if (s_cyc_o !== 1'b1 || m0_ack_o !== 1'b1)
            $display("FAIL reset_pre_burst: got cyc=%b ack=%b expected 1 1", s_cyc_o, m0_ack_o);
        else npass++;
        #2 wb_rst_n_i = 1'b0;
        #1;
        ntotal++;
        if ({s_cyc_o, s_stb_o, m0_ack_o} !== 3'b000)
            $display("FAIL reset_mid_burst: got cyc/stb/ack=%b expected 000", {s_cyc_o, s_stb_o, m0_ack_o});
        else npass++;
        m0_idle();
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        m0_req(32'h10, 32'h0, 1'b0, 3'b000, 2'b00);
        m1_req(32'h40, 32'h0, 1'b0, 3'b000, 2'b00);
        @(negedge wb_clk_i);
        ntotal++;
        if (s_cyc_o !== 1'b0)
            $display("FAIL sim_grant_latency: got cyc=%b expected 0", s_cyc_o);
        else npass++;
        tick();
        @(negedge wb_clk_i);
        ntotal++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h10)
            $display("FAIL sim_m0_first: got cyc=%b adr=%h expected 1 00000010", s_cyc_o, s_adr_o);
        else npass++;
        ntotal++;
        if ({m0_ack_o, m1_ack_o} !== 2'b10 || m0_dat_o !== 32'hA500_0004)
            $display("FAIL sim_m0_read: got ack=%b dat=%h expected 10 a5000004", {m0_ack_o, m1_ack_o}, m0_dat_o);
        else npass++;
        tick();
        m0_idle();
        @(negedge wb_clk_i);
        ntotal++;
        if (s_cyc_o !== 1'b0)
            $display("FAIL sim_handoff_gap: got cyc=%b expected 0", s_cyc_o);
        else npass++;
        tick();
        @(negedge wb_clk_i);
        ntotal++;
        if (s_adr_o !== 32'h40 || {m0_ack_o, m1_ack_o} !== 2'b01 || m1_dat_o !== 32'hA500_0010)
            $display("FAIL sim_m1_read: got adr=%h ack=%b dat=%h expected 00000040 01 a5000010",
                     s_adr_o, {m0_ack_o, m1_ack_o}, m1_dat_o);
        else npass++;
        tick();
        m1_idle();
        tick();
    endtask

    task automatic test_burst_lock();
        logic [31:0] a;
        logic [2:0]  cti;
        m1_req(32'h18, 32'h0, 1'b0, 3'b010, 2'b10);
        tick();
        m0_req(32'h80, 32'h0, 1'b0, 3'b000, 2'b00);
        for (int b = 0; b < 8; b++) begin
            a = (32'h18 + 32'(4 * b)) & 32'h1F;
            cti = (b == 7) ? 3'b111 : 3'b010;
            @(negedge wb_clk_i);
            ntotal++;
            if ({m1_ack_o, m0_ack_o} !== 2'b10 || s_adr_o !== a || m1_dat_o !== (32'hA500_0000 | (a >> 2))
                || s_cti_o !== cti || s_bte_o !== 2'b10)
                $display("FAIL burst_beat%0d: got ack=%b adr=%h dat=%h cti=%b bte=%b expected 10 %h %h %b 10",
                         b, {m1_ack_o, m0_ack_o}, s_adr_o, m1_dat_o, s_cti_o, s_bte_o,
                         a, 32'hA500_0000 | (a >> 2), cti);
            else npass++;
            tick();
            if (b < 7) begin
                m1_adr_i = (32'h18 + 32'(4 * (b + 1))) & 32'h1F;
                m1_cti_i = (b + 1 == 7) ? 3'b111 : 3'b010;
            end else begin
                m1_idle();
            end
        end
        @(negedge wb_clk_i);
        ntotal++;
        if (s_cyc_o !== 1'b0 || m0_ack_o !== 1'b0)
            $display("FAIL burst_release_gap: got cyc=%b m0_ack=%b expected 0 0", s_cyc_o, m0_ack_o);
        else npass++;
        tick();
        @(negedge wb_clk_i);
        ntotal++;
        if (m0_ack_o !== 1'b1 || s_adr_o !== 32'h80 || m0_dat_o !== 32'hA500_0020)
            $display("FAIL burst_m0_after: got ack=%b adr=%h dat=%h expected 1 00000080 a5000020",
                     m0_ack_o, s_adr_o, m0_dat_o);
        else npass++;
        tick();
        m0_idle();
        tick();
    endtask

    task automatic test_round_robin();
        int   done0 = 0;
        int   done1 = 0;
        int   ng = 0;
        int   order [8];
        logic a0, a1;
        do_reset();
        m0_req(32'h100, 32'h0000_1000, 1'b1, 3'b000, 2'b00);
        m1_req(32'h200, 32'h0000_2000, 1'b1, 3'b000, 2'b00);
        for (int c = 0; c < 40 && (done0 < 2 || done1 < 2); c++) begin
            @(negedge wb_clk_i);
            a0 = m0_ack_o;
            a1 = m1_ack_o;
            if (a0 && ng < 8) begin order[ng] = 0; ng++; end
            if (a1 && ng < 8) begin order[ng] = 1; ng++; end
            if ((a0 || a1) && s_sel_o !== 4'hF) begin
                ntotal++;
                $display("FAIL rr_sel: got %h expected f", s_sel_o);
            end
            tick();
            if (a0) begin m0_idle(); done0++; end
            else if (!m0_cyc_i && done0 < 2)
                m0_req(32'h100 + 32'(4 * done0), 32'h0000_1000 + 32'(done0), 1'b1, 3'b000, 2'b00);
            if (a1) begin m1_idle(); done1++; end
            else if (!m1_cyc_i && done1 < 2)
                m1_req(32'h200 + 32'(4 * done1), 32'h0000_2000 + 32'(done1), 1'b1, 3'b000, 2'b00);
        end
        ntotal++;
        if (ng !== 4)
            $display("FAIL rr_grant_count: got %0d expected 4", ng);
        else npass++;
        for (int k = 0; k < 4; k++) begin
            ntotal++;
            if (k >= ng || order[k] !== (k % 2))
                $display("FAIL rr_order%0d: got %0d expected %0d", k, (k < ng) ? order[k] : -1, k % 2);
            else npass++;
        end
        ntotal++;
        if (wmem[8'h40] !== 32'h1000 || wmem[8'h41] !== 32'h1001 || wmem[8'h80] !== 32'h2000 || wmem[8'h81] !== 32'h2001)
            $display("FAIL rr_memory: got %h %h %h %h expected 00001000 00001001 00002000 00002001",
                     wmem[8'h40], wmem[8'h41], wmem[8'h80], wmem[8'h81]);
        else npass++;
        tick();
    endtask

    task automatic test_error();
        m0_req(32'h0002_0000, 32'h0, 1'b0, 3'b000, 2'b00);
        tick();
        @(negedge wb_clk_i);
        ntotal++;
        if ({m0_err_o, m1_err_o, m0_ack_o} !== 3'b100)
            $display("FAIL err_passthru: got m0err/m1err/m0ack=%b expected 100", {m0_err_o, m1_err_o, m0_ack_o});
        else npass++;
        tick();
        m0_idle();
        @(negedge wb_clk_i);
        ntotal++;
        if (s_cyc_o !== 1'b0 || m0_err_o !== 1'b0)
            $display("FAIL err_release: got cyc=%b err=%b expected 0 0", s_cyc_o, m0_err_o);
        else npass++;
        tick();
        m1_req(32'h48, 32'h0, 1'b0, 3'b000, 2'b00);
        @(negedge wb_clk_i);
        ntotal++;
        if (s_cyc_o !== 1'b0)
            $display("FAIL err_back_to_idle: got cyc=%b expected 0", s_cyc_o);
        else npass++;
        tick();
        @(negedge wb_clk_i);
        ntotal++;
        if (m1_ack_o !== 1'b1 || m1_dat_o !== 32'hA500_0012)
            $display("FAIL err_next_grant: got ack=%b dat=%h expected 1 a5000012", m1_ack_o, m1_dat_o);
        else npass++;
        tick();
        m1_idle();
        tick();
    endtask

    task automatic test_watchdog();
        stall = 1'b1;
        m0_req(32'h4, 32'h0, 1'b0, 3'b000, 2'b00);
        tick();
        m1_req(32'h44, 32'h0, 1'b0, 3'b000, 2'b00);
`ifdef RAM_WB_ARB_WATCHDOG_EN
        for (int c = 1; c <= 4; c++) begin
            @(negedge wb_clk_i);
            ntotal++;
            if (m0_err_o !== 1'b0 || s_cyc_o !== 1'b1)
                $display("FAIL wdog_stall%0d: got err=%b cyc=%b expected 0 1", c, m0_err_o, s_cyc_o);
            else npass++;
            tick();
        end
        @(negedge wb_clk_i);
        ntotal++;
        if ({m0_err_o, s_cyc_o, s_stb_o} !== 3'b100)
            $display("FAIL wdog_fire: got err/cyc/stb=%b expected 100", {m0_err_o, s_cyc_o, s_stb_o});
        else npass++;
        tick();
        @(negedge wb_clk_i);
        ntotal++;
        if ({m0_err_o, s_cyc_o, m1_ack_o} !== 3'b000)
            $display("FAIL wdog_abort_hold: got err/cyc/m1ack=%b expected 000", {m0_err_o, s_cyc_o, m1_ack_o});
        else npass++;
        tick();
        m0_idle();
        stall = 1'b0;
        @(negedge wb_clk_i);
        ntotal++;
        if (s_cyc_o !== 1'b0)
            $display("FAIL wdog_abort_exit: got cyc=%b expected 0", s_cyc_o);
        else npass++;
        tick();
`else
        for (int c = 1; c <= 8; c++) begin
            @(negedge wb_clk_i);
            ntotal++;
            if (m0_err_o !== 1'b0 || s_cyc_o !== 1'b1 || s_adr_o !== 32'h4)
                $display("FAIL nowdog_hold%0d: got err=%b cyc=%b adr=%h expected 0 1 00000004",
                         c, m0_err_o, s_cyc_o, s_adr_o);
            else npass++;
            tick();
        end
        stall = 1'b0;
        @(negedge wb_clk_i);
        ntotal++;
        if (m0_ack_o !== 1'b1)
            $display("FAIL nowdog_late_ack: got %b expected 1", m0_ack_o);
        else npass++;
        tick();
        m0_idle();
        @(negedge wb_clk_i);
        tick();
`endif
        @(negedge wb_clk_i);
        ntotal++;
        if (m1_ack_o !== 1'b1 || s_adr_o !== 32'h44 || m1_dat_o !== 32'hA500_0011)
            $display("FAIL wdog_m1_grant: got ack=%b adr=%h dat=%h expected 1 00000044 a5000011",
                     m1_ack_o, s_adr_o, m1_dat_o);
        else npass++;
        tick();
        m1_idle();
        tick();
    endtask

    initial begin
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_cti_i = '0; m0_bte_i = '0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_cti_i = '0; m1_bte_i = '0;
        m0_idle();
        m1_idle();
        test_reset();
        test_simultaneous();
        test_burst_lock();
        test_round_robin();
        test_error();
        test_watchdog();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/ram_wb_arbiter.md
# ram_wb_arbiter

Two-master Wishbone B3 arbiter that shares a single `ram_wb_b3` slave port between the OR1200 instruction and data buses. It sits directly in front of the RAM. It grants the slave for whole bus cycles, so B3 bursts are never split. Grants use round-robin fairness. An optional watchdog aborts stalled cycles.

## Interface
Parameters:
- `dw`, 32: data width.
- `aw`, 32: address width.
- `WDOG_CYCLES`, 256: stall limit in clocks, range 1..65535. Used only with the watchdog.

Ports:
- `wb_clk_i` input 1: clock.
- `wb_rst_n_i` input 1: reset. Asynchronous, active-low.
- `m0_adr_i`/`m0_dat_i`/`m0_sel_i`/`m0_cti_i`/`m0_bte_i`/`m0_we_i`/`m0_stb_i`/`m0_cyc_i` input aw/dw/4/3/2/1/1/1: master 0 request (instruction bus).
- `m0_dat_o`/`m0_ack_o`/`m0_err_o`/`m0_rty_o` output dw/1/1/1: master 0 response.
- `m1_*` inputs and outputs: identical set for master 1 (data bus).
- `s_adr_o`/`s_dat_o`/`s_sel_o`/`s_cti_o`/`s_bte_o`/`s_we_o`/`s_stb_o`/`s_cyc_o` output aw/dw/4/3/2/1/1/1: slave request.
- `s_dat_i`/`s_ack_i`/`s_err_i`/`s_rty_i` input dw/1/1/1: slave response.

## Operation
States: IDLE, GNT0, GNT1, ABORT. ABORT exists only when `RAM_WB_ARB_WATCHDOG_EN` is defined.

Registered `last` pointer records the master granted most recently.

IDLE:
- Only m0_cyc high -> GNT0.
- Only m1_cyc high -> GNT1.
- Both high -> grant the master that is not `last`.
- Neither high -> stay in IDLE.

GNTx:
- Stay while mx_cyc_i is high. Burst lock holds through any cti/bte sequence.
- mx_cyc_i low and other master requesting -> GNTy directly (handoff).
- mx_cyc_i low and no other request -> IDLE.
- `last` updates to x on entry to GNTx.

Slave request:
- In GNTx, s_* = mx_* and s_cyc_o = mx_cyc_i.
- In IDLE/ABORT, s_cyc_o = s_stb_o = s_we_o = 0. Other s_* carry m0 values.

Responses:
- Granted master receives s_ack_i/s_err_i/s_rty_i combinationally.
- Non-granted master receives ack/err/rty = 0.
- m0_dat_o = m1_dat_o = s_dat_i, unconditionally.

Reset (asynchronous, any time, including mid-burst):
- state = IDLE, `last` = 1, so m0 wins the first tie.
- All s_cyc_o/s_stb_o/s_we_o and all m*_ack/err/rty = 0 immediately.

## Timing
- Grant latency:
  - mx_cyc_i rises in cycle n while in IDLE.
  - State is GNTx from edge n+1.
  - s_cyc_o is first high in cycle n+1.
- Handoff: mx_cyc_i low in cycle n with my_cyc_i high -> s_cyc_o low in cycle n (combinational gating) -> GNTy from edge n+1.
- No added latency on the response path. ack/err/rty/dat are pass-through.
- A master stalled waiting for grant keeps its stb/cyc asserted. It receives no ack until granted.
- A master that drops cyc while waiting is never granted.

## Configuration
Macro: `RAM_WB_ARB_WATCHDOG_EN`.

Defined:
- A 16-bit stall counter clears on state change or on any s_ack_i/s_err_i.
- It increments in GNTx while s_stb_o is high.
- When the counter equals WDOG_CYCLES:
  - The arbiter drives mx_err_o = 1 for exactly one cycle and enters ABORT.
  - The slave cyc/stb are forced low from that cycle on.
- ABORT holds until mx_cyc_i is low, then follows the IDLE rules on the next edge.

Not defined:
- No counter, no ABORT state.
- A stalled cycle holds the grant indefinitely.

## Test plan
- **Reset/idle:** hold wb_rst_n_i low, then release with no requests -> s_cyc_o = 0, all m*_ack_o = 0. Pull reset low mid-burst -> s_cyc_o = 0 in the same cycle.
- **Simultaneous request after reset:** m0 and m1 both raise cyc in cycle 0 -> m0 granted (s_adr_o = m0_adr_i) from cycle 1. When m0 drops cyc, m1 is granted on the next edge and its classic read returns its data with ack.
- **Burst lock:** m1 runs an 8-beat wrap burst (cti = 010, bte = 10) at 0x00000018 while m0 requests throughout -> all 8 acks go to m1. m0 is granted only after m1 cti = 111 and cyc is dropped.
- **Round-robin:** m0 and m1 continuously issue back-to-back single classic writes -> grants alternate m0, m1, m0, m1. Memory contents match both masters' data.
- **Slave error pass-through:** m0 accesses 0x00020000 -> m0_err_o asserted, m1_err_o = 0, arbiter returns to IDLE after m0 drops cyc.
- **Watchdog (macro defined, WDOG_CYCLES = 4):** model the slave to never ack -> m0_err_o pulses for one cycle on the 5th stalled cycle, s_cyc_o low from then on. A pending m1 request is granted after m0 drops cyc. Macro undefined -> no err, grant held.
